// File: rtl/dtcm_arb.sv
// dtcm_arb: shares the single DTCM port between the LSU and a DMA/debug
// requester. One access may be outstanding; a new one can be granted in the
// cycle the previous one completes. LSU has fixed priority, limited by a
// consecutive-grant counter so DMA is not starved. Malformed requests
// (load == store) are granted but answered locally without touching the DTCM.
module dtcm_arb #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // LSU requester
    input  logic          lsu_req,
    input  logic          lsu_load,
    input  logic          lsu_store,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [3:0]    lsu_mask,
    output logic          lsu_gnt,
    output logic          lsu_rsp,
    output logic [DW-1:0] lsu_rdata,
    // DMA / debug requester
    input  logic          dma_req,
    input  logic          dma_load,
    input  logic          dma_store,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic [3:0]    dma_mask,
    output logic          dma_gnt,
    output logic          dma_rsp,
    output logic [DW-1:0] dma_rdata,
    // DTCM side
    output logic          req_to_dtcm,
    output logic          load_to_dtcm,
    output logic          store_to_dtcm,
    output logic [AW-1:0] addr_to_dtcm,
    output logic [DW-1:0] store_data_to_dtcm,
    output logic [3:0]    store_mask_to_dtcm,
    input  logic          res_from_dtcm,
    input  logic [DW-1:0] data_from_dtcm,
    // status
    output logic          busy,
    output logic          err
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_BURST);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;   // 0 = LSU, 1 = DMA
    logic       local_q, local_d;   // outstanding access is answered internally
    logic       ld_q, ld_d;         // outstanding access is a load
    logic       err_q, err_d;
    logic [2:0] cnt_q, cnt_d;

    logic          outst;
    logic          rsp_now;
    logic          can_issue;
    logic          sel_dma;
    logic          sel_lsu;
    logic          grant;
    logic          win_load;
    logic          win_store;
    logic          malformed;
    logic [DW-1:0] rsp_data;

    // State register; reset drops any outstanding access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            local_q <= 1'b0;
            ld_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            local_q <= local_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Arbitration, DTCM muxing, response routing and next-state logic.
    always_comb begin
        state_d            = state_q;
        owner_d            = owner_q;
        local_d            = local_q;
        ld_d               = ld_q;
        err_d              = err_q;
        cnt_d              = cnt_q;
        lsu_gnt            = 1'b0;
        dma_gnt            = 1'b0;
        req_to_dtcm        = 1'b0;
        load_to_dtcm       = 1'b0;
        store_to_dtcm      = 1'b0;
        addr_to_dtcm       = '0;
        store_data_to_dtcm = '0;
        store_mask_to_dtcm = 4'b0000;
        lsu_rsp            = 1'b0;
        dma_rsp            = 1'b0;
        lsu_rdata          = '0;
        dma_rdata          = '0;

        outst     = (state_q == WAIT);
        rsp_now   = outst & (local_q | res_from_dtcm);
        can_issue = !outst | rsp_now;

        // DMA wins when LSU is idle or has used up its burst allowance.
        sel_dma   = can_issue & dma_req & (!lsu_req | (cnt_q == MAX_CNT));
        sel_lsu   = can_issue & lsu_req & !sel_dma;
        grant     = sel_dma | sel_lsu;
        win_load  = sel_dma ? dma_load  : lsu_load;
        win_store = sel_dma ? dma_store : lsu_store;
        malformed = (win_load == win_store);

        lsu_gnt = sel_lsu;
        dma_gnt = sel_dma;

        if (grant && !malformed) begin
            req_to_dtcm        = 1'b1;
            load_to_dtcm       = win_load;
            store_to_dtcm      = win_store;
            addr_to_dtcm       = sel_dma ? dma_addr  : lsu_addr;
            store_data_to_dtcm = sel_dma ? dma_wdata : lsu_wdata;
            store_mask_to_dtcm = sel_dma ? dma_mask  : lsu_mask;
        end

        // Response goes to the owner; data only for a real DTCM load.
        rsp_data = (!local_q && ld_q) ? data_from_dtcm : '0;
        if (rsp_now) begin
            if (owner_q) begin
                dma_rsp   = 1'b1;
                dma_rdata = rsp_data;
            end else begin
                lsu_rsp   = 1'b1;
                lsu_rdata = rsp_data;
            end
        end

        if (grant) begin
            state_d = WAIT;
            owner_d = sel_dma;
            local_d = malformed;
            ld_d    = win_load & !malformed;
        end else if (rsp_now) begin
            state_d = IDLE;
            local_d = 1'b0;
        end

        // A DTCM response we are not waiting for is a protocol error.
        if ((grant && malformed) || (res_from_dtcm && (!outst || local_q)))
            err_d = 1'b1;

        if (sel_dma || !dma_req)
            cnt_d = 3'd0;
        else if (sel_lsu && cnt_q != MAX_CNT)
            cnt_d = cnt_q + 3'd1;
    end

    assign busy = (state_q == WAIT);
    assign err  = err_q;

endmodule
